// File: rtl/regfile_scanner.sv
// -----------------------------------------------------------------------------
// regfile_scanner
//
// Walks a register file from FIRST_REG to LAST_REG and streams each word out
// over a valid/ready interface. Each register takes two cycles: READ drives the
// register-file address and captures the combinational read data, and SEND
// holds the word until downstream accepts it.
//
// Optional feature (macro SCAN_CHECKSUM_EN):
//   When defined, the XOR of all streamed data words follows the last register
//   as one extra word. That word has out_chk = 1, out_idx = 0 and out_last = 1.
//   When undefined, there is no checksum state or accumulator, and out_chk is
//   held at 0.
//
// Parameters:
//   FIRST_REG  first register index scanned (0..31, <= LAST_REG)
//   LAST_REG   last register index scanned (0..31)
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        synchronous active-high reset
//   start      requests one full scan; only looked at while idle
//   readReg    register-file read address (registered)
//   regData    register-file read data for readReg (same cycle)
//   out_data   streamed word
//   out_idx    register index of out_data (0 for the checksum word)
//   out_chk    out_data is the checksum word
//   out_last   out_data is the final word of the scan
//   out_valid  stream word valid
//   out_ready  downstream accepts the word when out_valid && out_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module regfile_scanner #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  readReg,
   input  logic [31:0] regData,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_chk,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef SCAN_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_CHK,
      S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_DONE
   } state_t;
`endif

   state_t      state;
   logic [4:0]  idx;
   logic        handshake;

`ifdef SCAN_CHECKSUM_EN
   logic [31:0] acc;
`endif

   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= 5'd0;
         readReg   <= 5'd0;
         out_data  <= 32'd0;
         out_idx   <= 5'd0;
         out_chk   <= 1'b0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
         acc       <= 32'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx     <= FIRST_IDX;
                  // readReg is registered, so it must already carry the index
                  // while the state is READ.
                  readReg <= FIRST_IDX;
                  busy    <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                  acc     <= 32'd0;
`endif
                  state   <= S_READ;
               end
            end

            S_READ: begin
               out_data  <= regData;
               out_idx   <= idx;
               out_chk   <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
               out_last  <= 1'b0;
`else
               out_last  <= (idx == LAST_IDX);
`endif
               out_valid <= 1'b1;
               state     <= S_SEND;
            end

            S_SEND: begin
               if (handshake) begin
`ifdef SCAN_CHECKSUM_EN
                  acc <= acc ^ out_data;
`endif
                  if (idx < LAST_IDX) begin
                     idx       <= idx + 5'd1;
                     readReg   <= idx + 5'd1;
                     out_valid <= 1'b0;
                     state     <= S_READ;
                  end else begin
`ifdef SCAN_CHECKSUM_EN
                     // The accepted word is folded in here directly, so the
                     // checksum can be presented in the very next cycle.
                     // out_valid stays high.
                     out_data  <= acc ^ out_data;
                     out_idx   <= 5'd0;
                     out_chk   <= 1'b1;
                     out_last  <= 1'b1;
                     state     <= S_CHK;
`else
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_DONE;
`endif
                  end
               end
            end

`ifdef SCAN_CHECKSUM_EN
            S_CHK: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
`endif

            S_DONE: begin
               // start is ignored here. busy drops on the same edge that
               // the state returns to IDLE.
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
